branch_cond_unit: RTL and testbench

//   Parametrised, registered branch-condition evaluator for the multicycle MIPS datapath.

---
 rtl/branch_cond_unit.sv | 83 ++++++++
 tb/tb_branch_cond_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: registered MIPS branch-condition evaluator with saturating taken/not-taken counters
module branch_cond_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic                 clr_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 taken,
  output logic                 pc_branch_we,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] taken_cnt,
  output logic [CNT_WIDTH-1:0] nt_cnt
);
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t state, state_nxt;
  logic [2:0] mode_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic cond, ill_q, neg, zero;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state: starts arriving outside IDLE are simply dropped
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE ? (start ? EVAL : IDLE) : state == EVAL ? RESP : IDLE;
  end
  // operand capture; later input changes cannot disturb the in-flight evaluation
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (state == IDLE && start) begin
      mode_q <= mode;
      a_q <= rs_data;
      b_q <= rt_data;
    end
  // condition from captured operands; sign taken from the MSB only
  always_comb begin
    neg = a_q[WIDTH-1];
    zero = a_q == '0;
    cond = mode_q == 3'd0 ? a_q == b_q :
           mode_q == 3'd1 ? a_q != b_q :
           mode_q == 3'd2 ? !neg && !zero :
           mode_q == 3'd3 ? neg || zero :
           mode_q == 3'd4 ? neg :
           mode_q == 3'd5 ? !neg :
           mode_q == 3'd6 ? !zero : 1'b0;
  end
  // result registered on leaving EVAL so it is valid throughout RESP and held afterwards
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      taken <= 1'b0;
      ill_q <= 1'b0;
    end else if (state == EVAL) begin
      taken <= cond;
      ill_q <= &mode_q;
    end
  // saturating statistics; a clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      taken_cnt <= '0;
      nt_cnt <= '0;
    end else if (clr_cnt) begin
      taken_cnt <= '0;
      nt_cnt <= '0;
    end else if (state == RESP) begin
      if (taken && !(&taken_cnt)) taken_cnt <= taken_cnt + CNT_WIDTH'(1);
      if (!taken && !(&nt_cnt)) nt_cnt <= nt_cnt + CNT_WIDTH'(1);
    end
  assign busy = state != IDLE;
  assign done = state == RESP;
  assign pc_branch_we = done & taken;
  assign illegal = done & ill_q;
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed self-checking bench for branch_cond_unit (CNT_WIDTH=2 to reach saturation)
module tb_branch_cond_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] mode = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic clr_cnt = 1'b0;
  logic busy, done, taken, pc_branch_we, illegal;
  logic [1:0] taken_cnt, nt_cnt;
  int total = 0;
  int passed = 0;
  int pulses;
  logic [5:0] pattern;

  branch_cond_unit #(.WIDTH(32), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .rs_data(rs_data), .rt_data(rt_data),
    .clr_cnt(clr_cnt), .busy(busy), .done(done), .taken(taken), .pc_branch_we(pc_branch_we),
    .illegal(illegal), .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("clr_nt_cnt", 32'(nt_cnt), 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                     input logic exp_t, input logic exp_i);
    start = 1'b1;
    mode = m;
    rs_data = a;
    rt_data = b;
    step();
    start = 1'b0;
    mode = ~m;
    rs_data = ~a;
    rt_data = a ^ 32'd1;
    chk({tag, "_eval_busy"}, 32'(busy), 32'd1);
    chk({tag, "_eval_done"}, 32'(done), 32'd0);
    step();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_taken"}, 32'(taken), 32'(exp_t));
    chk({tag, "_pc_we"}, 32'(pc_branch_we), 32'(exp_t));
    chk({tag, "_illegal"}, 32'(illegal), 32'(exp_i));
    step();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_held_taken"}, 32'(taken), 32'(exp_t));
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_pc_we", 32'(pc_branch_we), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_nt_cnt", 32'(nt_cnt), 32'd0);
    step();
    rst = 1'b0;
    run("beq_eq", 3'd0, 32'h1234, 32'h1234, 1'b1, 1'b0);
    chk("t1_taken_cnt", 32'(taken_cnt), 32'd1);
    chk("t1_nt_cnt", 32'(nt_cnt), 32'd0);
    run("bltz_min", 3'd4, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
    run("bgtz_min", 3'd2, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    run("blez_zero", 3'd3, 32'd0, 32'd7, 1'b1, 1'b0);
    run("bgez_zero", 3'd5, 32'd0, 32'd7, 1'b1, 1'b0);
    run("bnzu_one", 3'd6, 32'd1, 32'd0, 1'b1, 1'b0);
    run("bnzu_zero", 3'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    run("bgtz_pos", 3'd2, 32'h7fff_ffff, 32'd0, 1'b1, 1'b0);
    run("bne_eq", 3'd1, 32'h55, 32'h55, 1'b0, 1'b0);
    clear();
    start = 1'b1;
    mode = 3'd1;
    rs_data = 32'd1;
    rt_data = 32'd2;
    pulses = 0;
    pattern = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      pattern[i] = done;
      if (done) pulses++;
    end
    start = 1'b0;
    chk("held_start_pulses", 32'(pulses), 32'd2);
    chk("held_start_pattern", 32'(pattern), 32'b010010);
    chk("held_taken_cnt", 32'(taken_cnt), 32'd2);
    chk("held_nt_cnt", 32'(nt_cnt), 32'd0);
    run("illegal", 3'd7, 32'd9, 32'd9, 1'b0, 1'b1);
    chk("ill_nt_cnt", 32'(nt_cnt), 32'd1);
    chk("ill_taken_cnt", 32'(taken_cnt), 32'd2);
    clear();
    for (int i = 0; i < 5; i++) run("sat_beq", 3'd0, 32'(i), 32'(i), 1'b1, 1'b0);
    chk("sat_taken_cnt", 32'(taken_cnt), 32'd3);
    chk("sat_nt_cnt", 32'(nt_cnt), 32'd0);
    start = 1'b1;
    mode = 3'd0;
    rs_data = 32'd1;
    rt_data = 32'd2;
    step();
    start = 1'b0;
    step();
    chk("clr_resp_done", 32'(done), 32'd1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_win_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("clr_win_nt_cnt", 32'(nt_cnt), 32'd0);
    run("pre_rst", 3'd0, 32'd3, 32'd3, 1'b1, 1'b0);
    start = 1'b1;
    mode = 3'd0;
    rs_data = 32'd4;
    rt_data = 32'd4;
    step();
    start = 1'b0;
    chk("rst_mid_eval_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_taken", 32'(taken), 32'd0);
    step();
    rst = 1'b0;
    chk("rst_after_done", 32'(done), 32'd0);
    chk("rst_after_pc_we", 32'(pc_branch_we), 32'd0);
    run("post_rst", 3'd0, 32'd5, 32'd5, 1'b1, 1'b0);
    chk("post_rst_taken_cnt", 32'(taken_cnt), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
